// File: rtl/rf_pkg.sv
// Shared widths, index constants and types for the scoreboarded register file.
package rf_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_NREGS  = 2 ** DEF_ADDR_W;

  typedef logic [DEF_ADDR_W-1:0] reg_idx_t;
  typedef logic [DEF_DATA_W-1:0] reg_data_t;

  // Index 0 is the hardwired-zero register: never written, never pending.
  localparam reg_idx_t REG_ZERO = '0;

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-producer scoreboard: tracks in-flight destination registers and
// raises busy/stall for the decode stage.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter bit BYPASS = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic              busy1,
  output logic              busy2,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_dst,
  input  logic              issue_use1,
  input  logic              issue_use2,
  output logic              stall,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic              flush,
  output logic [ADDR_W:0]   pending_cnt
);

  localparam int NREGS = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

  logic [NREGS-1:0] pending;
  logic [NREGS-1:0] pending_nxt;
  logic [ADDR_W:0]  cnt_nxt;
  logic             wb_hit1;
  logic             wb_hit2;
  logic             waw;
  logic             accept;

  assign wb_hit1 = wb_valid && (wb_addr == rd_addr1);
  assign wb_hit2 = wb_valid && (wb_addr == rd_addr2);

  // A same-cycle writeback resolves the read hazard only if its data is forwarded.
  assign busy1 = pending[rd_addr1] && !(BYPASS && wb_hit1);
  assign busy2 = pending[rd_addr2] && !(BYPASS && wb_hit2);

  // The retiring producer frees the destination for reuse regardless of forwarding.
  assign waw = (issue_dst != ZERO_IDX) && pending[issue_dst] &&
               !(wb_valid && (wb_addr == issue_dst));

  assign stall  = issue_valid && ((issue_use1 && busy1) || (issue_use2 && busy2) || waw);
  assign accept = issue_valid && !stall;

  // Priority, lowest to highest: writeback clear, issue set, flush.
  always_comb begin
    pending_nxt = pending;
    if (wb_valid && (wb_addr != ZERO_IDX))
      pending_nxt[wb_addr] = 1'b0;
    if (accept && (issue_dst != ZERO_IDX))
      pending_nxt[issue_dst] = 1'b1;
    if (flush)
      pending_nxt = '0;
  end

  always_comb begin
    cnt_nxt = '0;
    for (int i = 0; i < NREGS; i++)
      cnt_nxt = cnt_nxt + {{ADDR_W{1'b0}}, pending_nxt[i]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending     <= '0;
      pending_cnt <= '0;
    end else begin
      pending     <= pending_nxt;
      pending_cnt <= cnt_nxt;
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// Parametrised GPR file with write-to-read bypass and a pending scoreboard
// that generates decode-stage hazards.
module regfile_sb
  import rf_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter bit RESET_INDEX = 1'b1,
  parameter bit BYPASS      = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  output logic              busy1,
  output logic              busy2,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_dst,
  input  logic              issue_use1,
  input  logic              issue_use2,
  output logic              stall,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              flush,
  output logic [ADDR_W:0]   pending_cnt
);

  localparam int NREGS = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

  logic [DATA_W-1:0] regs [NREGS];

  // Bring-up convention: optionally preload each register with its own index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++)
        regs[i] <= (RESET_INDEX && (i != 0)) ? DATA_W'(i) : '0;
    end else if (wb_valid && (wb_addr != ZERO_IDX)) begin
      regs[wb_addr] <= wb_data;
    end
  end

  assign rd_data1 = (rd_addr1 == ZERO_IDX) ? '0 :
                    (BYPASS && wb_valid && (wb_addr == rd_addr1)) ? wb_data : regs[rd_addr1];
  assign rd_data2 = (rd_addr2 == ZERO_IDX) ? '0 :
                    (BYPASS && wb_valid && (wb_addr == rd_addr2)) ? wb_data : regs[rd_addr2];

  rf_scoreboard #(
    .ADDR_W (ADDR_W),
    .BYPASS (BYPASS)
  ) u_scoreboard (
    .clk         (clk),
    .rst_n       (rst_n),
    .rd_addr1    (rd_addr1),
    .rd_addr2    (rd_addr2),
    .busy1       (busy1),
    .busy2       (busy2),
    .issue_valid (issue_valid),
    .issue_dst   (issue_dst),
    .issue_use1  (issue_use1),
    .issue_use2  (issue_use2),
    .stall       (stall),
    .wb_valid    (wb_valid),
    .wb_addr     (wb_addr),
    .flush       (flush),
    .pending_cnt (pending_cnt)
  );

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed scenarios with literal
// expectations, then randomized traffic against a behavioural model.
module tb_regfile_sb;
  import rf_pkg::*;

  logic      clk;
  logic      rst_n;
  reg_idx_t  rd_addr1, rd_addr2, issue_dst, wb_addr;
  reg_data_t rd_data1, rd_data2, wb_data;
  logic      busy1, busy2, stall;
  logic      issue_valid, issue_use1, issue_use2, wb_valid, flush;
  logic [DEF_ADDR_W:0] pending_cnt;

  int checks = 0;
  int errors = 0;
  logic compare_en = 1'b0;

  reg_data_t model_regs [DEF_NREGS];
  bit        model_pend [DEF_NREGS];

  regfile_sb #(
    .DATA_W      (DEF_DATA_W),
    .ADDR_W      (DEF_ADDR_W),
    .RESET_INDEX (1'b1),
    .BYPASS      (1'b1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rd_addr1    (rd_addr1),
    .rd_addr2    (rd_addr2),
    .rd_data1    (rd_data1),
    .rd_data2    (rd_data2),
    .busy1       (busy1),
    .busy2       (busy2),
    .issue_valid (issue_valid),
    .issue_dst   (issue_dst),
    .issue_use1  (issue_use1),
    .issue_use2  (issue_use2),
    .stall       (stall),
    .wb_valid    (wb_valid),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .flush       (flush),
    .pending_cnt (pending_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: architectural register values and the set of in-flight producers.
  function automatic reg_data_t model_read(input reg_idx_t a);
    if (a == 0) return '0;
    if (wb_valid && wb_addr == a) return wb_data;
    return model_regs[a];
  endfunction

  function automatic logic model_busy(input reg_idx_t a);
    return model_pend[a] && !(wb_valid && wb_addr == a);
  endfunction

  function automatic logic model_stall();
    logic waw;
    waw = (issue_dst != 0) && model_pend[issue_dst] && !(wb_valid && wb_addr == issue_dst);
    return issue_valid && ((issue_use1 && model_busy(rd_addr1)) ||
                           (issue_use2 && model_busy(rd_addr2)) || waw);
  endfunction

  function automatic int model_count();
    int n = 0;
    foreach (model_pend[i]) n += int'(model_pend[i]);
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      foreach (model_regs[i]) begin
        model_regs[i] = reg_data_t'(i);
        model_pend[i] = 1'b0;
      end
    end else begin
      logic accepted;
      accepted = issue_valid && !model_stall();
      if (wb_valid && wb_addr != 0) begin
        model_regs[wb_addr] = wb_data;
        model_pend[wb_addr] = 1'b0;
      end
      if (accepted && issue_dst != 0) model_pend[issue_dst] = 1'b1;
      if (flush) foreach (model_pend[i]) model_pend[i] = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (compare_en) begin
      check_output("rd_data1", rd_data1, model_read(rd_addr1));
      check_output("rd_data2", rd_data2, model_read(rd_addr2));
      check_output("busy1", 32'(busy1), 32'(model_busy(rd_addr1)));
      check_output("busy2", 32'(busy2), 32'(model_busy(rd_addr2)));
      check_output("stall", 32'(stall), 32'(model_stall()));
      check_output("pending_cnt", 32'(pending_cnt), 32'(model_count()));
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic apply_idle();
    issue_valid = 1'b0; issue_dst = '0; issue_use1 = 1'b0; issue_use2 = 1'b0;
    wb_valid = 1'b0; wb_addr = '0; wb_data = '0; flush = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  function automatic reg_idx_t pick_addr();
    if ($urandom_range(0, 3) == 0) return reg_idx_t'($urandom_range(0, 31));
    return reg_idx_t'($urandom_range(0, 7));
  endfunction

  initial begin
    rst_n = 1'b1;
    apply_idle();
    rd_addr1 = 5'd7; rd_addr2 = 5'd0;
    #1 rst_n = 1'b0;
    #2 compare_en = 1'b1;
    check_output("reset_rd1", rd_data1, 32'd7);
    check_output("reset_rd2", rd_data2, 32'd0);
    check_output("reset_busy", {30'd0, busy1, busy2}, 32'd0);
    check_output("reset_stall", 32'(stall), 32'd0);
    check_output("reset_cnt", 32'(pending_cnt), 32'd0);
    #9 rst_n = 1'b1;

    // Bypass and write persistence
    step();
    wb_valid = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEADBEEF; rd_addr1 = 5'd5;
    settle();
    check_output("bypass_rd1", rd_data1, 32'hDEADBEEF);
    step();
    wb_valid = 1'b0;
    settle();
    check_output("write_rd1", rd_data1, 32'hDEADBEEF);
    step();
    wb_valid = 1'b1; wb_addr = 5'd0; wb_data = 32'h1234; rd_addr1 = 5'd0;
    settle();
    check_output("zero_bypass", rd_data1, 32'd0);
    step();
    wb_valid = 1'b0;
    settle();
    check_output("zero_write", rd_data1, 32'd0);

    // RAW hazard resolved by writeback
    step();
    issue_valid = 1'b1; issue_dst = 5'd8;
    settle();
    check_output("issue8_stall", 32'(stall), 32'd0);
    step();
    issue_dst = 5'd0; issue_use1 = 1'b1; rd_addr1 = 5'd8;
    settle();
    check_output("raw_busy1", 32'(busy1), 32'd1);
    check_output("raw_stall", 32'(stall), 32'd1);
    check_output("raw_cnt", 32'(pending_cnt), 32'd1);
    wb_valid = 1'b1; wb_addr = 5'd8; wb_data = 32'hA5A5_0008;
    settle();
    check_output("raw_wb_busy1", 32'(busy1), 32'd0);
    check_output("raw_wb_stall", 32'(stall), 32'd0);
    step();
    apply_idle();
    settle();
    check_output("raw_cnt_after", 32'(pending_cnt), 32'd0);

    // WAW hazard, and set-wins against a same-cycle clear
    issue_valid = 1'b1; issue_dst = 5'd9;
    step();
    settle();
    check_output("waw_stall", 32'(stall), 32'd1);
    step();
    settle();
    check_output("waw_cnt", 32'(pending_cnt), 32'd1);
    wb_valid = 1'b1; wb_addr = 5'd9; wb_data = 32'h0000_0099;
    settle();
    check_output("waw_wb_stall", 32'(stall), 32'd0);
    step();
    apply_idle();
    rd_addr1 = 5'd9;
    settle();
    check_output("setwins_cnt", 32'(pending_cnt), 32'd1);
    check_output("setwins_busy1", 32'(busy1), 32'd1);
    wb_valid = 1'b1; wb_addr = 5'd9; wb_data = 32'h0000_0999;
    step();
    apply_idle();
    settle();
    check_output("clear9_cnt", 32'(pending_cnt), 32'd0);

    // Flush beats a same-cycle issue
    issue_valid = 1'b1; issue_dst = 5'd3;
    step(); issue_dst = 5'd4;
    step(); issue_dst = 5'd5;
    step(); issue_valid = 1'b0;
    settle();
    check_output("three_cnt", 32'(pending_cnt), 32'd3);
    issue_valid = 1'b1; issue_dst = 5'd6; flush = 1'b1;
    step();
    apply_idle();
    rd_addr1 = 5'd3; rd_addr2 = 5'd6;
    settle();
    check_output("flush_cnt", 32'(pending_cnt), 32'd0);
    check_output("flush_busy", {30'd0, busy1, busy2}, 32'd0);
    check_output("flush_rd1", rd_data1, 32'd3);
    rd_addr1 = 5'd5; rd_addr2 = 5'd4;
    settle();
    check_output("flush_busy_b", {30'd0, busy1, busy2}, 32'd0);
    check_output("flush_rd5", rd_data1, 32'hDEADBEEF);

    // Asynchronous reset between edges while r10 is pending
    step();
    issue_valid = 1'b1; issue_dst = 5'd10;
    wb_valid = 1'b1; wb_addr = 5'd10; wb_data = 32'h55;
    step();
    apply_idle();
    rd_addr1 = 5'd10;
    settle();
    check_output("r10_data", rd_data1, 32'h55);
    check_output("r10_cnt", 32'(pending_cnt), 32'd1);
    rst_n = 1'b0;
    #1;
    check_output("arst_cnt", 32'(pending_cnt), 32'd0);
    check_output("arst_rd10", rd_data1, 32'd10);
    check_output("arst_busy1", 32'(busy1), 32'd0);
    #4 rst_n = 1'b1;
    step();
    issue_valid = 1'b1; issue_dst = 5'd12;
    step();
    apply_idle();
    rd_addr2 = 5'd12;
    settle();
    check_output("post_rst_cnt", 32'(pending_cnt), 32'd1);
    check_output("post_rst_busy2", 32'(busy2), 32'd1);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      step();
      rd_addr1    = pick_addr();
      rd_addr2    = pick_addr();
      issue_valid = 1'($urandom_range(0, 1));
      issue_dst   = pick_addr();
      issue_use1  = 1'($urandom_range(0, 1));
      issue_use2  = 1'($urandom_range(0, 1));
      wb_valid    = ($urandom_range(0, 2) != 0);
      wb_addr     = pick_addr();
      wb_data     = $urandom();
      flush       = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 249) == 0) begin
        #1 rst_n = 1'b0;
        #2 rst_n = 1'b1;
      end
    end

    step();
    apply_idle();
    step();
    compare_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
